// File: rtl/imem_pkg.sv
// Shared types and constants for the instruction-memory responder.
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_e;

    localparam logic [31:0] ERR_INSTR = 32'h0;
    localparam int          CNT_W     = 4;

    // Misaligned, or beyond the top of a 2**dl2-word array.
    function automatic logic addr_err(input logic [31:0] a, input int dl2);
        return (a[1:0] != 2'b00) || ((a >> (dl2 + 2)) != 32'h0);
    endfunction

endpackage

// File: rtl/imem_array.sv
// Instruction storage: synchronous write, combinational read, contents not reset.
module imem_array #(
    parameter int DEPTH_LOG2 = 8
) (
    input  logic                  clk_i,
    input  logic                  we_i,
    input  logic [DEPTH_LOG2-1:0] waddr_i,
    input  logic [31:0]           wdata_i,
    input  logic [DEPTH_LOG2-1:0] raddr_i,
    output logic [31:0]           rdata_o
);

    logic [31:0] mem_q [2**DEPTH_LOG2];

    always_ff @(posedge clk_i) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/imem_responder.sv
// Fetch-side responder: one outstanding request, fixed wait states, flushable.
module imem_responder
    import imem_pkg::*;
#(
    parameter int DEPTH_LOG2  = 8,
    parameter int WAIT_STATES = 2
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ReqValid,
    input  logic [31:0]           ReqAddr,
    output logic                  ReqReady,
    output logic                  RespValid,
    output logic [31:0]           RespInstr,
    output logic [31:0]           RespAddr,
    output logic                  AddrErr,
    input  logic                  RespReady,
    input  logic                  Flush,
    input  logic                  LoadEn,
    input  logic [DEPTH_LOG2-1:0] LoadAddr,
    input  logic [31:0]           LoadData
);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               valid_q, valid_d;
    logic [31:0]        instr_q, instr_d;
    logic [31:0]        addr_q, addr_d;
    logic               err_q, err_d;

    logic [31:0]        rd_byte;
    logic [31:0]        rd_data;
    logic               rd_err;
    logic               accept;

    // WAIT reads the latched address; zero-wait accesses read straight from the request.
    assign rd_byte = (state_q == WAIT) ? addr_q : ReqAddr;
    assign rd_err  = addr_err(rd_byte, DEPTH_LOG2);

    imem_array #(.DEPTH_LOG2(DEPTH_LOG2)) u_array (
        .clk_i   (CLK),
        .we_i    (LoadEn),
        .waddr_i (LoadAddr),
        .wdata_i (LoadData),
        .raddr_i (rd_byte[DEPTH_LOG2+1:2]),
        .rdata_o (rd_data)
    );

    assign ReqReady = !Flush && (state_q == IDLE || (state_q == RESP && RespReady));
    assign accept   = ReqValid && ReqReady;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        instr_d = instr_q;
        addr_d  = addr_q;
        err_d   = err_q;
        if (Flush) begin
            state_d = IDLE;
            cnt_d   = '0;
            valid_d = 1'b0;
        end else begin
            case (state_q)
                WAIT: begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = RESP;
                        valid_d = 1'b1;
                        instr_d = rd_err ? ERR_INSTR : rd_data;
                        err_d   = rd_err;
                    end
                end
                RESP: begin
                    if (RespReady) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                    end
                end
                default: ;
            endcase
            if (accept) begin
                addr_d = ReqAddr;
                if (WAIT_STATES == 0) begin
                    state_d = RESP;
                    valid_d = 1'b1;
                    instr_d = rd_err ? ERR_INSTR : rd_data;
                    err_d   = rd_err;
                end else begin
                    state_d = WAIT;
                    cnt_d   = CNT_W'(WAIT_STATES);
                    valid_d = 1'b0;
                end
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            valid_q <= 1'b0;
            instr_q <= '0;
            addr_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
            instr_q <= instr_d;
            addr_q  <= addr_d;
            err_q   <= err_d;
        end
    end

    assign RespValid = valid_q;
    assign RespInstr = instr_q;
    assign RespAddr  = addr_q;
    assign AddrErr   = err_q;

endmodule
